// File: rtl/rst_ack_rsp.sv
// rst_ack_rsp
//
// Responder end of the HSSI reset request/acknowledge handshake. A level
// reset request from the upstream sequencer makes this block:
//   1. quiesce the local datapath and wait for outstanding traffic to drain.
//      The wait is bounded by a timeout.
//   2. assert the local reset for a guaranteed minimum number of cycles.
//   3. return an acknowledge and hold it until the request is withdrawn.
//   4. release the local reset, then keep the acknowledge for a settle delay
//      before dropping it.
//
// Ports
//   i_clk        clock, single domain
//   i_rst        synchronous active-high block reset
//   i_rst_req    level reset request from the initiator
//   i_busy       downstream still has outstanding traffic
//   o_quiesce    blocks new traffic into the sub-block
//   o_local_rst  reset to the sub-block
//   o_ack        acknowledge to the initiator
//   o_drain_to   one-cycle pulse: the drain wait ended by timeout
//
// All outputs are registered and decoded from the next state, so each output
// changes on the same edge as the state register.

module rst_ack_rsp #(
    parameter int MIN_RST_CYCLES = 16,
    parameter int DRAIN_TIMEOUT  = 1024,
    parameter int RELEASE_DELAY  = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rst_req,
    input  logic i_busy,
    output logic o_quiesce,
    output logic o_local_rst,
    output logic o_ack,
    output logic o_drain_to
);

    // One counter is shared by every timed state, so it is sized for the
    // longest interval.
    localparam int MAX_DH  = (DRAIN_TIMEOUT > MIN_RST_CYCLES) ? DRAIN_TIMEOUT : MIN_RST_CYCLES;
    localparam int MAX_CYC = (MAX_DH > RELEASE_DELAY) ? MAX_DH : RELEASE_DELAY;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter starts at 0 on state entry. The last cycle of an N-cycle
    // interval therefore sees count N-1.
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(RELEASE_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        HOLD    = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cnt_run;
    logic             quiesce_next;
    logic             local_rst_next;
    logic             ack_next;
    logic             drain_to_next;

    // State, counter and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            o_quiesce   <= 1'b0;
            o_local_rst <= 1'b0;
            o_ack       <= 1'b0;
            o_drain_to  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            o_quiesce   <= quiesce_next;
            o_local_rst <= local_rst_next;
            o_ack       <= ack_next;
            o_drain_to  <= drain_to_next;
        end
    end

    // Next-state logic, counter update and output decode
    always_comb begin
        state_next    = state;
        cnt_run       = 1'b0;
        drain_to_next = 1'b0;

        case (state)
            IDLE: begin
                if (i_rst_req) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                cnt_run = 1'b1;
                // An abort beats both exits to HOLD. A drain that completes
                // on the timeout cycle is a normal drain and gives no pulse.
                if (!i_rst_req) begin
                    state_next = IDLE;
                end else if (!i_busy) begin
                    state_next = HOLD;
                end else if (cnt == DRAIN_LAST) begin
                    state_next    = HOLD;
                    drain_to_next = 1'b1;
                end
            end

            HOLD: begin
                cnt_run = 1'b1;
                if (cnt == HOLD_LAST) begin
                    state_next = ACK;
                end
            end

            ACK: begin
                if (!i_rst_req) begin
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                cnt_run = 1'b1;
                if (cnt == REL_LAST) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The counter clears on every state change. Each timed state leaves
        // at its last count, so the counter never wraps.
        if (state_next != state) begin
            cnt_next = '0;
        end else if (cnt_run) begin
            cnt_next = cnt + CNT_W'(1);
        end else begin
            cnt_next = cnt;
        end

        quiesce_next   = (state_next != IDLE);
        local_rst_next = (state_next == HOLD) || (state_next == ACK);
        ack_next       = (state_next == ACK) || (state_next == RELEASE);
    end

endmodule
